// File: rtl/bcd_seq_conv.sv
// Iterative binary-to-BCD converter, one double-dabble step per clock.
// Define BCD_SAT_EN to clamp overflowed results to all nines.
module bcd_seq_conv #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [BIN_W-1:0] r_shift;
  logic [BW-1:0]    r_bcd;
  logic             r_ovf;

  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_nxt;
  logic             w_ovf_nxt;
  logic             w_last;
  logic [BW-1:0]    w_res;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // The top adjusted bit falls off the end: that is the overflow.
  assign w_nxt     = {w_adj[BW-2:0], r_shift[BIN_W-1]};
  assign w_ovf_nxt = r_ovf | w_adj[BW-1];
  assign w_last    = (r_cnt == CW'(BIN_W - 1));

`ifdef BCD_SAT_EN
  assign w_res = w_ovf_nxt ? {DIGITS{4'h9}} : w_nxt;
`else
  assign w_res = w_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      ovf     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_shift <= bin_in;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_bcd   <= w_nxt;
          r_shift <= {r_shift[BIN_W-2:0], 1'b0};
          r_ovf   <= w_ovf_nxt;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            bcd_out <= w_res;
            ovf     <= w_ovf_nxt;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Bench for bcd_seq_conv: default 8-bit instance and a 10-bit instance.
module tb_bcd_seq_conv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [7:0]  bin_a = '0;
  logic [9:0]  bin_b = '0;
  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;
  logic [11:0] bcd_a, bcd_b;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bcd_seq_conv u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .bin_in(bin_a), .busy(busy_a), .done(done_a),
    .bcd_out(bcd_a), .ovf(ovf_a)
  );

  bcd_seq_conv #(.BIN_W(10), .DIGITS(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .bin_in(bin_b), .busy(busy_b), .done(done_b),
    .bcd_out(bcd_b), .ovf(ovf_b)
  );

`ifdef BCD_SAT_EN
  localparam logic [11:0] E1023 = 12'h999;
  localparam logic [11:0] E1000 = 12'h999;
`else
  localparam logic [11:0] E1023 = 12'h023;
  localparam logic [11:0] E1000 = 12'h000;
`endif

  // Reference result {ovf, bcd} from plain decimal arithmetic.
  function automatic logic [12:0] ref_conv(input int v);
    int m;
    logic [11:0] r;
    logic o;
    m = v % 1000;
    o = (v > 999);
    r = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
`ifdef BCD_SAT_EN
    if (o) r = 12'h999;
`endif
    return {o, r};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: phase 0 idle, 1..W busy, W+1 done.
  int          ph_a, ph_b;
  logic [7:0]  cap_a;
  logic [9:0]  cap_b;
  logic [12:0] res_a, res_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_a <= 0; cap_a <= '0; res_a <= '0;
    end else if (ph_a == 0) begin
      if (start_a) begin
        ph_a <= 1; cap_a <= bin_a;
      end
    end else if (ph_a == 8) begin
      ph_a <= 9; res_a <= ref_conv(int'(cap_a));
    end else if (ph_a == 9) begin
      ph_a <= 0;
    end else begin
      ph_a <= ph_a + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_b <= 0; cap_b <= '0; res_b <= '0;
    end else if (ph_b == 0) begin
      if (start_b) begin
        ph_b <= 1; cap_b <= bin_b;
      end
    end else if (ph_b == 10) begin
      ph_b <= 11; res_b <= ref_conv(int'(cap_b));
    end else if (ph_b == 11) begin
      ph_b <= 0;
    end else begin
      ph_b <= ph_b + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy_a", int'(busy_a), int'(ph_a >= 1 && ph_a <= 8));
      chk("done_a", int'(done_a), int'(ph_a == 9));
      chk("bcd_a", int'(bcd_a), int'(res_a[11:0]));
      chk("ovf_a", int'(ovf_a), int'(res_a[12]));
      chk("busy_b", int'(busy_b), int'(ph_b >= 1 && ph_b <= 10));
      chk("done_b", int'(done_b), int'(ph_b == 11));
      chk("bcd_b", int'(bcd_b), int'(res_b[11:0]));
      chk("ovf_b", int'(ovf_b), int'(res_b[12]));
    end
  end

  task automatic run_a(input logic [7:0] v, input logic [11:0] ev,
                       input logic eo, input string nm);
    int n;
    @(negedge clk); start_a = 1'b1; bin_a = v;
    @(negedge clk); start_a = 1'b0; bin_a = ~v;
    n = 1;
    while (!done_a && n < 20) begin
      @(negedge clk); n++;
    end
    chk({nm, "_lat"}, n, 9);
    chk({nm, "_bcd"}, int'(bcd_a), int'(ev));
    chk({nm, "_ovf"}, int'(ovf_a), int'(eo));
  endtask

  task automatic run_b(input logic [9:0] v, input logic [11:0] ev,
                       input logic eo, input string nm);
    int n;
    @(negedge clk); start_b = 1'b1; bin_b = v;
    @(negedge clk); start_b = 1'b0; bin_b = ~v;
    n = 1;
    while (!done_b && n < 20) begin
      @(negedge clk); n++;
    end
    chk({nm, "_lat"}, n, 11);
    chk({nm, "_bcd"}, int'(bcd_b), int'(ev));
    chk({nm, "_ovf"}, int'(ovf_b), int'(eo));
  endtask

  initial begin
    int cnt;
    int last;
    logic [11:0] got;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_bcd", int'(bcd_a), 0);
    chk("rst_ovf", int'(ovf_a), 0);
    #2 rst_n = 1'b1;

    run_a(8'd0, 12'h000, 1'b0, "zero");
    run_a(8'd255, 12'h255, 1'b0, "v255");
    run_a(8'd99, 12'h099, 1'b0, "v99");
    run_a(8'd10, 12'h010, 1'b0, "v10");

    // Start pulse during CONV must be ignored.
    @(negedge clk); start_a = 1'b1; bin_a = 8'd200;
    @(negedge clk); start_a = 1'b0; bin_a = 8'd0;
    cnt = 0; got = '0;
    for (int i = 1; i < 25; i++) begin
      if (done_a) begin
        cnt++; got = bcd_a;
      end
      if (i == 4) begin
        start_a = 1'b1; bin_a = 8'd7;
      end else begin
        start_a = 1'b0;
      end
      @(negedge clk);
    end
    chk("ign_cnt", cnt, 1);
    chk("ign_bcd", int'(got), 'h200);
    run_a(8'd7, 12'h007, 1'b0, "after_ign");

    // Reset mid-conversion.
    @(negedge clk); start_a = 1'b1; bin_a = 8'd123;
    @(negedge clk); start_a = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done_a) cnt++;
    end
    chk("abort_done", cnt, 0);
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_bcd", int'(bcd_a), 0);
    run_a(8'd45, 12'h045, 1'b0, "post_rst");

    run_b(10'd1023, E1023, 1'b1, "b1023");
    run_b(10'd999, 12'h999, 1'b0, "b999");
    run_b(10'd1000, E1000, 1'b1, "b1000");
    run_b(10'd512, 12'h512, 1'b0, "b512");

    // Continuous start: one result every BIN_W+2 cycles.
    @(negedge clk); start_a = 1'b1; bin_a = 8'd37;
    cnt = 0; last = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_a) begin
        cnt++;
        chk("cont_bcd", int'(bcd_a), 'h037);
        if (last >= 0) chk("cont_period", i - last, 10);
        last = i;
      end
    end
    chk("cont_cnt", cnt, 3);
    start_a = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
